mdr: RTL and testbench
======================

// Module: mdr
// PURPOSE
//   Memory Data Register for the Mini SRC datapath: a 32-bit register sitting
//   between the internal bus and the memory data port. Loads either the bus
//   value (CPU write path) or memory read data, selected by 'read'. Output
//   drives the bus mux and the memory write-data port.
// PARAMETERS
//   DATA_WIDTH   32   width of data path, bus input, memory input and output
// PORTS
//   clk          in   1           system clock; all state changes on rising edge
//   clr          in   1           reset, synchronous, active-high
//   mdr_in       in   1           load enable
//   read         in   1           source select: 1 = mdatain, 0 = bus_mux_out
//   bus_mux_out  in   DATA_WIDTH  data from internal bus
//   mdatain      in   DATA_WIDTH  data from memory
//   mdr_out      out  DATA_WIDTH  registered MDR contents
// BEHAVIOUR
//   - Single clock, one register; mdr_out is the register output directly
//     (no combinational path from any input to mdr_out).
//   - On each rising clk edge, evaluated in this priority order:
//       1. clr=1           -> register <= 0 (mdr_in/read ignored)
//       2. mdr_in=1        -> register <= read ? mdatain : bus_mux_out
//       3. otherwise       -> register holds
//   - Reset value of mdr_out: all zeros. Power-up value before the first clr
//     edge is undefined; the system asserts clr before use.
//   - Latency: a load is visible on mdr_out immediately after the capturing
//     edge (1 cycle). No handshake; mdr_in is a level sampled per edge.
//   - mdr_in held high for N edges reloads on every edge (tracks selected
//     source). read is ignored when mdr_in=0.
//   - Source mux is a pure width-preserving select; no sign/zero extension.
//   - clr asserted mid-sequence overrides any concurrent load that edge.
//   - No FSM; no internal state beyond the data register.
// STRUCTURE
//   - Shared package: DATA_WIDTH default (32) as datapath width constant.
//   - Natural sub-module: mux_2to1 (DATA_WIDTH-wide, sel=read) feeding the
//     register; register with sync clear and enable coded in mdr itself.
// TESTING
//   - clr=1 for one edge, other inputs 0 -> mdr_out = 32'h00000000.
//   - clr=0, read=0, mdr_in=1, bus_mux_out=32'hA5A5A5A5, one edge
//     -> mdr_out = 32'hA5A5A5A5.
//   - read=1, mdr_in=1, mdatain=32'hDEADBEEF, one edge
//     -> mdr_out = 32'hDEADBEEF.
//   - mdr_in=0, change bus_mux_out/mdatain/read over several edges
//     -> mdr_out holds 32'hDEADBEEF.
//   - clr=1 with mdr_in=1, read=1, mdatain=32'h12345678, one edge
//     -> mdr_out = 32'h00000000 (clear wins).
//   - Change inputs between edges with mdr_in=1 -> mdr_out changes only at
//     rising clk, never mid-cycle.

Source files
------------

// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared datapath constants for the memory data register
package mdr_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

endpackage : mdr_pkg

// File: rtl/mdr_mux_2to1.sv
// rtl/mdr_mux_2to1.sv - width-preserving two-input select feeding the MDR
module mdr_mux_2to1 #(
  parameter int DATA_WIDTH = mdr_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule : mdr_mux_2to1

// File: rtl/mdr.sv
// rtl/mdr.sv - memory data register loading bus or memory data, sync clear
module mdr
  import mdr_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  mdr_in,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] bus_mux_out,
  input  logic [DATA_WIDTH-1:0] mdatain,
  output logic [DATA_WIDTH-1:0] mdr_out
);

  logic [DATA_WIDTH-1:0] load_data;

  mdr_mux_2to1 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_src_mux (
    .sel(read),
    .in0(bus_mux_out),
    .in1(mdatain),
    .out(load_data)
  );

  // Clear takes priority over any concurrent load on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      mdr_out <= '0;
    end else if (mdr_in) begin
      mdr_out <= load_data;
    end
  end

endmodule : mdr

// File: tb/tb_mdr.sv
// tb/tb_mdr.sv - scoreboard bench for the memory data register
module tb_mdr;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         mdr_in = 1'b0;
  logic         read = 1'b0;
  logic [W-1:0] bus_mux_out = '0;
  logic [W-1:0] mdatain = '0;
  logic [W-1:0] mdr_out;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  bit           stim_done = 1'b0;

  always #5 clk = ~clk;

  mdr #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .clr(clr),
    .mdr_in(mdr_in),
    .read(read),
    .bus_mux_out(bus_mux_out),
    .mdatain(mdatain),
    .mdr_out(mdr_out)
  );

  // Inputs change 2 time units after each rising edge, so the negedge sample
  // also confirms that mid-cycle input changes do not leak to mdr_out.
  task automatic step(input string nm, input logic c, input logic en,
                      input logic rd, input logic [W-1:0] b,
                      input logic [W-1:0] m, input logic [W-1:0] expv);
    clr = c;
    mdr_in = en;
    read = rd;
    bus_mux_out = b;
    mdatain = m;
    @(posedge clk);
    exp_q.push_back(expv);
    name_q.push_back(nm);
    #2;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (mdr_out !== e) begin
        failures++;
        $display("FAIL %s: mdr_out=%h expected=%h", n, mdr_out, e);
      end
    end
  end

  initial begin
    @(posedge clk);
    #2;
    step("reset",        1, 0, 0, 32'h0,        32'h0,        32'h00000000);
    step("load_bus",     0, 1, 0, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5);
    step("load_mem",     0, 1, 1, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    step("hold_1",       0, 0, 0, 32'h11111111, 32'h22222222, 32'hDEADBEEF);
    step("hold_2",       0, 0, 1, 32'h33333333, 32'h44444444, 32'hDEADBEEF);
    step("hold_3",       0, 0, 0, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF);
    step("clr_wins",     1, 1, 1, 32'h0,        32'h12345678, 32'h00000000);
    step("bus_msb",      0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    step("mem_ones",     0, 1, 1, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step("track_1",      0, 1, 1, 32'hAAAAAAAA, 32'h0000FFFF, 32'h0000FFFF);
    step("track_2",      0, 1, 0, 32'h5555AAAA, 32'h0000FFFF, 32'h5555AAAA);
    step("track_3",      0, 1, 0, 32'h00000001, 32'h7FFFFFFF, 32'h00000001);
    step("hold_after",   0, 0, 1, 32'h0,        32'hCAFEF00D, 32'h00000001);
    step("clr_nload",    1, 0, 0, 32'h9ABCDEF0, 32'h0,        32'h00000000);
    step("clr_hold",     0, 0, 1, 32'h9ABCDEF0, 32'hCAFEF00D, 32'h00000000);
    step("reload_mem",   0, 1, 1, 32'h9ABCDEF0, 32'hCAFEF00D, 32'hCAFEF00D);
    mdr_in = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while ((!stim_done || exp_q.size() > 0) && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (exp_q.size() > 0 || !stim_done) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_mdr
